// File: rtl/dm_wb_cache_controller_if.sv
// Request and memory bus bundle for the direct-mapped write-back cache.
// The slave view is the cache controller. The master view is the CPU together
// with the backing memory that surround the controller.
interface dm_wb_cache_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU request/response side
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr_req;
  logic [DATA_W-1:0] data_wr;
  logic [DATA_W-1:0] data_rd;
  logic [ADDR_W-1:0] addr_resp;
  logic              rdy;
  logic              busy;

  // single-word memory side
  logic              rd_mem;
  logic              wr_mem;
  logic              busy_mem;
  logic [ADDR_W-1:0] addr_mem;
  logic [DATA_W-1:0] data_wr_mem;
  logic [DATA_W-1:0] data_rd_mem;

  modport slave (
    input  rd, wr, addr_req, data_wr, busy_mem, data_rd_mem,
    output data_rd, addr_resp, rdy, busy, rd_mem, wr_mem, addr_mem, data_wr_mem
  );

  modport master (
    output rd, wr, addr_req, data_wr, busy_mem, data_rd_mem,
    input  data_rd, addr_resp, rdy, busy, rd_mem, wr_mem, addr_mem, data_wr_mem
  );
endinterface

// File: rtl/dm_wb_cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller.
// Hits complete through RESP without memory traffic. A miss first writes back
// a dirty victim word by word, then fills the line word by word, then responds.
// Every memory transfer is a one-cycle strobe followed by waiting for the first
// cycle with busy_mem low; only one transfer is ever outstanding.
module dm_wb_cache_controller #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  dm_wb_cache_controller_if.slave bus,
  output logic [CNT_W-1:0]       cache_hit_count,
  output logic [CNT_W-1:0]       cache_miss_count,
  output logic [CNT_W-1:0]       cache_wb_count
);

  localparam int LINES   = 1 << INDEX_W;
  localparam int WORDS   = 1 << OFFSET_W;
  localparam int TAG_LSB = INDEX_W + OFFSET_W + 2;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  // storage: tags and data are plain arrays, valid/dirty are flag vectors
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES][WORDS];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  state_t            state_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;
  logic              req_wr_q;
  logic [OFFSET_W-1:0] word_q;
  logic              pend_q;

  logic              rd_mem_q;
  logic              wr_mem_q;
  logic [ADDR_W-1:0] addr_mem_q;
  logic [DATA_W-1:0] data_wr_mem_q;
  logic [DATA_W-1:0] data_rd_q;
  logic [ADDR_W-1:0] addr_resp_q;
  logic              rdy_q;
  logic              busy_q;
  logic [CNT_W-1:0]  hit_count_q;
  logic [CNT_W-1:0]  miss_count_q;
  logic [CNT_W-1:0]  wb_count_q;

  // address fields of the live request and of the latched request
  logic [TAG_W-1:0]    in_tag;
  logic [INDEX_W-1:0]  in_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_word;
  logic [OFFSET_W-1:0] next_word;
  logic                lookup_hit;
  logic                victim_dirty;
  logic                xfer_done;
  logic                last_word;

  assign in_tag   = bus.addr_req[ADDR_W-1:TAG_LSB];
  assign in_idx   = bus.addr_req[TAG_LSB-1:OFFSET_W+2];
  assign req_tag  = req_addr_q[ADDR_W-1:TAG_LSB];
  assign req_idx  = req_addr_q[TAG_LSB-1:OFFSET_W+2];
  assign req_word = req_addr_q[OFFSET_W+1:2];

  assign next_word    = word_q + OFFSET_W'(1);
  assign last_word    = &word_q;
  assign lookup_hit   = valid_q[in_idx] && (tag_arr[in_idx] == in_tag);
  assign victim_dirty = valid_q[in_idx] && dirty_q[in_idx];
  // the strobe cycle itself never completes a transfer
  assign xfer_done    = pend_q && !rd_mem_q && !wr_mem_q && !bus.busy_mem;

  // Line storage updates: fill words, tag at end of fill, CPU write in RESP.
  // NOTE: tag/data arrays carry no reset; valid_q alone decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (state_q == S_FILL && xfer_done) begin
      data_arr[req_idx][word_q] <= bus.data_rd_mem;
      if (last_word) begin
        tag_arr[req_idx] <= req_tag;
      end
    end
    if (state_q == S_RESP && req_wr_q) begin
      data_arr[req_idx][req_word] <= req_data_q;
    end
  end

  // Control FSM with registered strobes, response outputs and statistics.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      req_addr_q    <= '0;
      req_data_q    <= '0;
      req_wr_q      <= 1'b0;
      word_q        <= '0;
      pend_q        <= 1'b0;
      rd_mem_q      <= 1'b0;
      wr_mem_q      <= 1'b0;
      addr_mem_q    <= '0;
      data_wr_mem_q <= '0;
      data_rd_q     <= '0;
      addr_resp_q   <= '0;
      rdy_q         <= 1'b0;
      busy_q        <= 1'b0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      wb_count_q    <= '0;
    end else begin
      // single-cycle pulses fall back to 0 unless re-armed below
      rdy_q    <= 1'b0;
      rd_mem_q <= 1'b0;
      wr_mem_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.rd || bus.wr) begin
            busy_q     <= 1'b1;
            req_addr_q <= bus.addr_req;
            req_data_q <= bus.data_wr;
            req_wr_q   <= bus.wr;
            word_q     <= '0;
            if (lookup_hit) begin
              hit_count_q <= hit_count_q + CNT_W'(1);
              state_q     <= S_RESP;
            end else begin
              miss_count_q    <= miss_count_q + CNT_W'(1);
              valid_q[in_idx] <= 1'b0;
              pend_q          <= 1'b1;
              if (victim_dirty) begin
                state_q       <= S_WB;
                wr_mem_q      <= 1'b1;
                addr_mem_q    <= {tag_arr[in_idx], in_idx, {OFFSET_W{1'b0}}, 2'b00};
                data_wr_mem_q <= data_arr[in_idx][0];
              end else begin
                state_q    <= S_FILL;
                rd_mem_q   <= 1'b1;
                addr_mem_q <= {in_tag, in_idx, {OFFSET_W{1'b0}}, 2'b00};
              end
            end
          end
        end

        S_WB: begin
          if (xfer_done) begin
            if (last_word) begin
              wb_count_q       <= wb_count_q + CNT_W'(1);
              dirty_q[req_idx] <= 1'b0;
              word_q           <= '0;
              state_q          <= S_FILL;
              rd_mem_q         <= 1'b1;
              addr_mem_q       <= {req_tag, req_idx, {OFFSET_W{1'b0}}, 2'b00};
            end else begin
              word_q        <= next_word;
              wr_mem_q      <= 1'b1;
              addr_mem_q    <= {tag_arr[req_idx], req_idx, next_word, 2'b00};
              data_wr_mem_q <= data_arr[req_idx][next_word];
            end
          end
        end

        S_FILL: begin
          if (xfer_done) begin
            if (last_word) begin
              valid_q[req_idx] <= 1'b1;
              pend_q           <= 1'b0;
              state_q          <= S_RESP;
            end else begin
              word_q     <= next_word;
              rd_mem_q   <= 1'b1;
              addr_mem_q <= {req_tag, req_idx, next_word, 2'b00};
            end
          end
        end

        S_RESP: begin
          rdy_q       <= 1'b1;
          busy_q      <= 1'b0;
          addr_resp_q <= req_addr_q;
          if (req_wr_q) begin
            dirty_q[req_idx] <= 1'b1;
          end else begin
            data_rd_q <= data_arr[req_idx][req_word];
          end
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_mem      = rd_mem_q;
  assign bus.wr_mem      = wr_mem_q;
  assign bus.addr_mem    = addr_mem_q;
  assign bus.data_wr_mem = data_wr_mem_q;
  assign bus.data_rd     = data_rd_q;
  assign bus.addr_resp   = addr_resp_q;
  assign bus.rdy         = rdy_q;
  assign bus.busy        = busy_q;

  assign cache_hit_count  = hit_count_q;
  assign cache_miss_count = miss_count_q;
  assign cache_wb_count   = wb_count_q;

endmodule

// File: tb/tb_dm_wb_cache_controller.sv
// Scoreboard bench for the direct-mapped write-back cache controller.
// A line-granular reference model predicts memory traffic and responses; a
// memory responder and a response monitor compare what the DUT actually does.
module tb_dm_wb_cache_controller;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

  always #5 clk = ~clk;

  dm_wb_cache_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_wb_cache_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(4), .OFFSET_W(2), .CNT_W(CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .cache_hit_count  (hit_cnt),
    .cache_miss_count (miss_cnt),
    .cache_wb_count   (wb_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fixed_delay = 0;
  int fill_seen   = 0;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_op_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] hits;
    logic [31:0] misses;
    logic [31:0] wbs;
    int          start_cyc;
    bit          is_hit;
  } resp_t;

  mem_op_t mem_q[$];
  resp_t   resp_q[$];

  // reference model: 16 lines of 16 bytes, identified by their base address
  bit          ref_valid [16];
  bit          ref_dirty [16];
  logic [31:0] ref_base  [16];
  logic [31:0] ref_data  [16][4];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_hits, ref_misses, ref_wbs, ref_last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'hA5A5_0001;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_word(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
    ref_hits    = 0;
    ref_misses  = 0;
    ref_wbs     = 0;
    ref_last_rd = 0;
  endtask

  // Applies one CPU access to the model, queueing the memory traffic and response it implies.
  task automatic model_access(input bit is_wr, input logic [31:0] addr,
                              input logic [31:0] data, input int start_cyc);
    logic [31:0] base;
    int line, w;
    bit hit;
    resp_t r;
    base = addr & ~32'hF;
    line = int'((addr / 16) % 16);
    w    = int'((addr / 4) % 4);
    hit  = ref_valid[line] && (ref_base[line] == base);
    if (hit) begin
      ref_hits++;
    end else begin
      ref_misses++;
      if (ref_valid[line] && ref_dirty[line]) begin
        for (int k = 0; k < 4; k++) begin
          mem_q.push_back('{1'b1, ref_base[line] + 32'(4 * k), ref_data[line][k]});
          ref_mem[ref_base[line] + 32'(4 * k)] = ref_data[line][k];
        end
        ref_wbs++;
      end
      for (int k = 0; k < 4; k++) begin
        mem_q.push_back('{1'b0, base + 32'(4 * k), ref_rd(base + 32'(4 * k))});
        ref_data[line][k] = ref_rd(base + 32'(4 * k));
      end
      ref_valid[line] = 1'b1;
      ref_dirty[line] = 1'b0;
      ref_base[line]  = base;
    end
    if (is_wr) begin
      ref_data[line][w] = data;
      ref_dirty[line]   = 1'b1;
    end else begin
      ref_last_rd = ref_data[line][w];
    end
    r.addr      = addr;
    r.data      = ref_last_rd;
    r.hits      = ref_hits;
    r.misses    = ref_misses;
    r.wbs       = ref_wbs;
    r.start_cyc = start_cyc;
    r.is_hit    = hit;
    resp_q.push_back(r);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: checks each strobe against the predicted traffic and answers it.
  initial begin
    mem_op_t got, exp;
    int d;
    bus.busy_mem    = 1'b0;
    bus.data_rd_mem = '0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.rd_mem || bus.wr_mem)) begin
        got.is_wr = bus.wr_mem;
        got.addr  = bus.addr_mem;
        got.data  = bus.data_wr_mem;
        check("strobe_exclusive", 32'(bus.rd_mem & bus.wr_mem), 32'd0);
        if (mem_q.size() == 0) begin
          fail_now($sformatf("mem_unexpected wr=%0b addr=0x%08h", got.is_wr, got.addr));
        end else begin
          exp = mem_q.pop_front();
          check("mem_kind", 32'(got.is_wr), 32'(exp.is_wr));
          check("mem_addr", got.addr, exp.addr);
          if (exp.is_wr) check("mem_wdata", got.data, exp.data);
        end
        if (got.is_wr) phys_mem[got.addr] = got.data;
        else fill_seen++;
        d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
        bus.busy_mem = 1'b1;
        for (int i = 0; i < d; i++) begin
          bus.data_rd_mem = $urandom;
          @(negedge clk);
          if (!rst) begin
            check("strobe_single", 32'(bus.rd_mem | bus.wr_mem), 32'd0);
            if (got.is_wr) check("wdata_stable", bus.data_wr_mem, got.data);
          end
        end
        bus.busy_mem    = 1'b0;
        bus.data_rd_mem = got.is_wr ? $urandom : phys_rd(got.addr);
      end
    end
  end

  // Response monitor: compares every rdy pulse with the oldest predicted response.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rdy) begin
        if (resp_q.size() == 0) begin
          fail_now($sformatf("rdy_unexpected addr_resp=0x%08h", bus.addr_resp));
        end else begin
          e = resp_q.pop_front();
          check("addr_resp", bus.addr_resp, e.addr);
          check("data_rd", bus.data_rd, e.data);
          check("busy_at_rdy", 32'(bus.busy), 32'd0);
          check("hit_count", hit_cnt, e.hits);
          check("miss_count", miss_cnt, e.misses);
          check("wb_count", wb_cnt, e.wbs);
          if (e.is_hit) check("hit_latency", 32'(cyc - e.start_cyc), 32'd2);
        end
      end
    end
  end

  // Issues one request and waits for its completion, optionally pulsing
  // ignored requests while busy or resetting during the given fill word.
  task automatic do_req(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                        input bit noise, input int abort_fill);
    bit done;
    @(negedge clk);
    check("idle_before_req", 32'(bus.busy), 32'd0);
    fill_seen = 0;
    model_access(is_wr, addr, data, cyc);
    bus.wr       = is_wr;
    bus.rd       = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.addr_req = addr;
    bus.data_wr  = data;
    @(negedge clk);
    bus.rd       = 1'b0;
    bus.wr       = 1'b0;
    bus.addr_req = $urandom;
    bus.data_wr  = $urandom;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    done = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (bus.rdy) begin
        done = 1'b1;
        break;
      end
      if (abort_fill > 0 && fill_seen >= abort_fill) begin
        rst = 1'b1;
        #1;
        check("abort_rd_mem", 32'(bus.rd_mem), 32'd0);
        check("abort_wr_mem", 32'(bus.wr_mem), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rdy", 32'(bus.rdy), 32'd0);
        model_reset();
        resp_q.delete();
        mem_q.delete();
        repeat (2) @(negedge clk);
        check("abort_hit_count", hit_cnt, 32'd0);
        check("abort_miss_count", miss_cnt, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        return;
      end
      if (noise && bus.busy) begin
        bus.rd       = 1'($urandom_range(0, 1));
        bus.wr       = 1'($urandom_range(0, 1));
        bus.addr_req = $urandom;
      end
      @(negedge clk);
      bus.rd = 1'b0;
      bus.wr = 1'b0;
    end
    if (!done) fail_now($sformatf("rdy_timeout addr=0x%08h", addr));
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.addr_req = '0;
    bus.data_wr  = '0;
    model_reset();
    #12;
    check("rst_rdy", 32'(bus.rdy), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_mem", 32'(bus.rd_mem), 32'd0);
    check("rst_wr_mem", 32'(bus.wr_mem), 32'd0);
    check("rst_addr_mem", bus.addr_mem, 32'd0);
    check("rst_data_wr_mem", bus.data_wr_mem, 32'd0);
    check("rst_data_rd", bus.data_rd, 32'd0);
    check("rst_addr_resp", bus.addr_resp, 32'd0);
    check("rst_hit_count", hit_cnt, 32'd0);
    check("rst_miss_count", miss_cnt, 32'd0);
    check("rst_wb_count", wb_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // cold miss, hit in same line, write hit, read-back, dirty conflict miss
    do_req(1'b0, 32'h0000_0104, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h0000_0108, 32'h0, 1'b0, 0);
    do_req(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 0);
    do_req(1'b0, 32'h0000_0104, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h0000_1104, 32'h0, 1'b0, 0);

    // slow memory with ignored requests pulsed while busy
    fixed_delay = 6;
    do_req(1'b0, 32'h0000_2204, 32'h0, 1'b1, 0);
    do_req(1'b1, 32'h0000_2208, 32'h1234_5678, 1'b1, 0);
    do_req(1'b0, 32'h0000_3204, 32'h0, 1'b1, 0);
    fixed_delay = 0;

    // randomized mix over a few tags so conflicts and write-backs are frequent
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 5)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h00A0_0000;
      do_req(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), 0);
    end

    // reset during the second fill word, then the same line must miss again
    fixed_delay = 4;
    do_req(1'b0, 32'h0000_3100, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h0000_1104, 32'h0, 1'b0, 2);
    do_req(1'b0, 32'h0000_1104, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h0000_1108, 32'h0, 1'b0, 0);
    fixed_delay = 0;

    repeat (4) @(negedge clk);
    check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    check("mem_queue_empty", 32'(mem_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule
